mem_responder: RTL
==================

Name: mem_responder

Overview:
- On-chip memory responder that implements the memory side of the arbiter request/response protocol, the same side the SDRAM controller serves.
- It sits on an arbiter's `mem` port in place of `sdram`. Uses: simulation, SDRAM bring-up bypass, and small on-chip framebuffers.
- It accepts single-word writes and BURST-word reads from an arbitrated client.
- It returns read data tagged with the requesting client's id.

Parameters:
- AN, 24, request address width
- DN, 16, data word width
- IN, 2, client id width
- BURST, 8, words returned per read request; power of two, 2..32
- DEPTH_LOG2, 10, log2 of internal storage words; addr[DEPTH_LOG2-1:0] selects the word and upper address bits alias
- LATENCY, 2, cycles from the read accept edge to the first valid word; range 1..4

Ports:
- clkSYS  in  1  system clock; everything is synchronous to it
- n_reset  in  1  asynchronous active-low reset
- req  in  1  client request; held with addr/data/wr/id until ack
- wr  in  1  1 = write, 0 = read
- addr  in  AN  word address
- data  in  DN  write data
- id  in  IN  requesting client id
- ack  out  1  request accepted this cycle (combinational)
- mem  out  DN  read data word
- mem_id  out  IN  id of the read that owns the current word
- valid  out  1  mem/mem_id hold a burst word this cycle
- busy  out  1  read burst in progress

Behaviour:
- Reset (asynchronous, n_reset low):
  - valid=0, busy=0, mem=0, mem_id=0, internal ready=0, burst counter=0, LATENCY pipeline cleared.
  - RAM contents are not cleared.
  - ready is set at the first clkSYS edge after n_reset rises. ack=0 until then, regardless of req.
- ack = req & ready & ~busy. A request is accepted at the clkSYS edge that ends an ack-high cycle.
  - The client changes its request fields only after that edge.
- Write accept: RAM[addr[DEPTH_LOG2-1:0]] <= data at the accept edge. Single word; no response. busy unaffected.
- Read accept:
  - At the accept edge: busy<=1; base address, start offset and id are latched.
  - Word k (k=0..BURST-1) is RAM[{base[DEPTH_LOG2-1:log2 BURST], (start+k) mod BURST}]. The offset wraps inside the BURST-aligned block; the upper bits are fixed.
  - valid=1 with word 0 during the LATENCY-th cycle after the accept edge, then 1 for BURST consecutive cycles, no gaps.
  - mem_id = latched id for all BURST words.
  - Example: LATENCY=1 puts word 0 in the cycle right after the accept edge.
- busy:
  - Falls at the edge that drives the last word.
  - ack may therefore assert (back-to-back read or write) in the cycle the last word is on mem.
  - Minimum read-to-read spacing is LATENCY+BURST-1 cycles.
- While busy, ack=0 for reads and writes. A request held during busy is stalled, not dropped, and is acked once busy falls.
- valid=0 ⇒ mem holds its last value and mem_id is don't-care. Benches compare only when valid=1.
- RAM read port is synchronous. The LATENCY pipeline carries valid, offset and id alongside the data.
- Reset mid-burst: valid and busy drop immediately and the remaining words are discarded. The first request after reset is served normally.
- Storage: one simple dual-port RAM of 2^DEPTH_LOG2 × DN, inferred from behavioural code; no vendor macro.

Test Plan:
- Reset/ready: hold req=1 through reset release → ack=0 while n_reset=0 and in the first cycle after release; ack=1 in the next cycle; exactly one request accepted.
- Write then read: write data=16'h1000+i to addr 24'h000010+i for i=0..7, then read addr 24'h000010 id=2 → valid for exactly 8 cycles starting 2 cycles after the accept edge; mem=16'h1000..16'h1007 in order; mem_id=2 throughout.
- Wrap: read addr 24'h000015 id=1 (same data) → mem sequence 1005,1006,1007,1000,1001,1002,1003,1004.
- Stall/back-to-back:
  - Issue read id=0, then immediately a write req.
  - Required: ack low until the last read word cycle; write acked in that cycle.
  - Required: a subsequent read of the written address returns the new value.
- Aliasing: with DEPTH_LOG2=10, write 16'hBEEF to addr 24'hF00400, then read addr 24'h000000 → word 0 = 16'hBEEF.
- Reset mid-burst: assert n_reset low after the 3rd valid word → valid and busy fall immediately; no further words after release; next read returns the full 8 correct words.

Source files
------------

// File: rtl/mem_responder.sv
// On-chip memory responder for the arbiter mem port.
// Accepts single-word writes and BURST-word wrapping reads; read data is
// returned LATENCY cycles after the accept edge, tagged with the client id.
module mem_responder #(
  parameter int AN         = 24,
  parameter int DN         = 16,
  parameter int IN         = 2,
  parameter int BURST      = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          req,
  input  logic          wr,
  input  logic [AN-1:0] addr,
  input  logic [DN-1:0] data,
  input  logic [IN-1:0] id,
  output logic          ack,
  output logic [DN-1:0] mem,
  output logic [IN-1:0] mem_id,
  output logic          valid,
  output logic          busy
);
  localparam int BL    = $clog2(BURST);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                     ready_q;
  logic                     busy_q, busy_d;
  logic                     issuing_q, issuing_d;
  logic [BL-1:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-BL-1:0] base_q;
  logic [BL-1:0]            start_q;
  logic [IN-1:0]            id_q;

  logic                  accept, rd_acc, wr_acc;
  logic                  vld0;
  logic [BL-1:0]         idx0;
  logic [IN-1:0]         id0;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  vld_last;
  logic [BL-1:0]         idx_last;

  logic [DN-1:0] ram [DEPTH];

  // Pipeline stage 1 is the synchronous RAM read register; stage LATENCY drives the outputs.
  logic          vld_q [1:LATENCY];
  logic [DN-1:0] dat_q [1:LATENCY];
  logic [IN-1:0] idp_q [1:LATENCY];

  // Upper address bits alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[AN-1:DEPTH_LOG2];

  assign accept = req & ready_q & ~busy_q;
  assign rd_acc = accept & ~wr;
  assign wr_acc = accept & wr;
  assign ack    = accept;
  assign busy   = busy_q;

  // Word 0 is read straight from the request address at the accept edge,
  // the remaining words from the latched base with a wrapping offset.
  assign vld0    = rd_acc | issuing_q;
  assign idx0    = rd_acc ? '0 : cnt_q;
  assign id0     = rd_acc ? id : id_q;
  assign rd_addr = rd_acc ? addr[DEPTH_LOG2-1:0] : {base_q, start_q + cnt_q};

  // Word index travels down the pipeline so busy can drop on the edge that
  // loads the last word into the output stage.
  generate
    if (LATENCY == 1) begin : g_l1
      assign vld_last = vld0;
      assign idx_last = idx0;
    end else begin : g_ln
      logic [BL-1:0] idx_q [1:LATENCY-1];
      // Shift the word index alongside the valid bits.
      always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
          for (int j = 1; j < LATENCY; j++) idx_q[j] <= '0;
        end else begin
          idx_q[1] <= idx0;
          for (int j = 2; j < LATENCY; j++) idx_q[j] <= idx_q[j-1];
        end
      end
      assign vld_last = vld_q[LATENCY-1];
      assign idx_last = idx_q[LATENCY-1];
    end
  endgenerate

  // Burst issue counter and busy flag next state.
  always_comb begin
    busy_d    = busy_q;
    issuing_d = issuing_q;
    cnt_d     = cnt_q;
    if (rd_acc) begin
      busy_d    = 1'b1;
      issuing_d = 1'b1;
      cnt_d     = BL'(1);
    end else if (issuing_q) begin
      cnt_d = cnt_q + BL'(1);
      if (cnt_q == BL'(BURST-1)) issuing_d = 1'b0;
    end
    if (vld_last && idx_last == BL'(BURST-1)) busy_d = 1'b0;
  end

  // Control registers; ready rises on the first edge after reset release.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      issuing_q <= 1'b0;
      cnt_q     <= '0;
      base_q    <= '0;
      start_q   <= '0;
      id_q      <= '0;
    end else begin
      ready_q   <= 1'b1;
      busy_q    <= busy_d;
      issuing_q <= issuing_d;
      cnt_q     <= cnt_d;
      if (rd_acc) begin
        base_q  <= addr[DEPTH_LOG2-1:BL];
        start_q <= addr[BL-1:0];
        id_q    <= id;
      end
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clkSYS) begin
    if (wr_acc) ram[addr[DEPTH_LOG2-1:0]] <= data;
  end

  // Read pipeline; data/id stages only load with a valid word so mem holds when idle.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      for (int j = 1; j <= LATENCY; j++) begin
        vld_q[j] <= 1'b0;
        dat_q[j] <= '0;
        idp_q[j] <= '0;
      end
    end else begin
      vld_q[1] <= vld0;
      if (vld0) begin
        dat_q[1] <= ram[rd_addr];
        idp_q[1] <= id0;
      end
      for (int j = 2; j <= LATENCY; j++) begin
        vld_q[j] <= vld_q[j-1];
        if (vld_q[j-1]) begin
          dat_q[j] <= dat_q[j-1];
          idp_q[j] <= idp_q[j-1];
        end
      end
    end
  end

  assign valid  = vld_q[LATENCY];
  assign mem    = dat_q[LATENCY];
  assign mem_id = idp_q[LATENCY];
endmodule
